// File: rtl/mem_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_store_unit_pkg
// Shared types for the store path:
//   load_size_e    - access width encoding (reused by loads and stores)
//   store_fault_e  - completion status reported with the store done pulse
//   store_state_e  - store FSM state encoding
// Helper functions translate an access width into its byte-lane mask.
// -----------------------------------------------------------------------------
package mem_store_unit_pkg;

    typedef enum logic [2:0] {
        BYTE      = 3'b000,
        HALF_WORD = 3'b001,
        WORD      = 3'b010
    } load_size_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_SIZE     = 2'b10,
        FLT_TIMEOUT  = 2'b11
    } store_fault_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10,
        ST_DONE  = 2'b11
    } store_state_e;

    // Byte-lane mask of an access starting at lane 0; unknown encodings give 0.
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        logic [3:0] mask;
        case (size)
            BYTE:      mask = 4'b0001;
            HALF_WORD: mask = 4'b0011;
            WORD:      mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // True for the three legal width encodings.
    function automatic logic size_is_valid(input logic [2:0] size);
        logic ok;
        case (size)
            BYTE, HALF_WORD, WORD: ok = 1'b1;
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_store_unit_lane_align.sv
// -----------------------------------------------------------------------------
// store_lane_align
// Combinational lane placement for a store. The data and strobe are shifted
// across a two-word (8-byte) window so that the low half feeds the first bus
// beat and the high half feeds the second beat of a word-crossing store.
// Ports:
//   i_off      - byte offset within the word (address bits [1:0])
//   i_size     - access width (load_size_e encoding)
//   i_data     - right-aligned store data
//   o_wdata    - 64-bit lane-shifted data (low word = beat 0, high = beat 1)
//   o_wstrb    - 8-bit lane-shifted strobe (low nibble = beat 0)
//   o_size_ok  - width encoding is legal
//   o_cross    - access spills into the next word
// -----------------------------------------------------------------------------
module store_lane_align
    import mem_store_unit_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic [31:0] i_data,
    output logic [63:0] o_wdata,
    output logic [7:0]  o_wstrb,
    output logic        o_size_ok,
    output logic        o_cross
);

    logic [3:0] w_mask;
    logic [7:0] w_wide_strb;

    // Shift data and strobe by the byte offset across the two-word window.
    always_comb begin
        w_mask      = size_mask(i_size);
        w_wide_strb = {4'b0000, w_mask} << i_off;
        o_wdata     = {32'h0000_0000, i_data} << {i_off, 3'b000};
    end

    assign o_wstrb   = w_wide_strb;
    assign o_size_ok = size_is_valid(i_size);
    // Any strobe in the upper nibble means the access needs a second word.
    assign o_cross   = |w_wide_strb[7:4];

endmodule

// File: rtl/mem_store_unit.sv
// -----------------------------------------------------------------------------
// mem_store_unit
// Accepts one store at a time from the core and writes it to a word-wide bus
// as one beat, or as two beats when the store crosses a word boundary and
// splitting is enabled. Every accepted store retires with a one-cycle done
// pulse carrying a fault code.
//
// Build option: define MISALIGNED_SPLIT_EN to split word-crossing stores into
// two beats; otherwise such stores are rejected with FLT_MISALIGN and no beat.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - store request handshake (ready only when idle)
//   req_addr/data/size    - byte address, right-aligned data, width
//   done, fault           - retire pulse and its status (FLT_NONE when idle)
//   bus_valid/bus_ready   - write beat handshake
//   bus_addr              - word-aligned beat address
//   bus_wdata, bus_wstrb  - lane-shifted data and byte enables
// -----------------------------------------------------------------------------
module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32'd32,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [2:0]        req_size,
    output logic              done,
    output logic [1:0]        fault,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb
);

`ifdef MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    // The wait counter never needs to hold more than TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
    localparam int unsigned TO_LAST = TIMEOUT_CYCLES - 32'd1;

    store_state_e      r_state;
    logic              r_req_ready;
    logic              r_done;
    store_fault_e      r_fault;
    logic              r_bus_valid;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [31:0]       r_bus_wdata;
    logic [3:0]        r_bus_wstrb;
    logic [31:0]       r_hi_wdata;
    logic [3:0]        r_hi_wstrb;
    logic              r_cross;
    logic [CNT_W-1:0]  r_wait;

    logic [63:0]       w_wdata;
    logic [7:0]        w_wstrb;
    logic              w_size_ok;
    logic              w_cross;
    logic              w_handshake;

    // Alignment is computed from the live request so both beats can be
    // captured in the same cycle the store is accepted.
    store_lane_align u_align (
        .i_off     (req_addr[1:0]),
        .i_size    (req_size),
        .i_data    (req_data),
        .o_wdata   (w_wdata),
        .o_wstrb   (w_wstrb),
        .o_size_ok (w_size_ok),
        .o_cross   (w_cross)
    );

    assign w_handshake = req_valid & r_req_ready;

    // Store FSM: request capture, beat sequencing, per-beat timeout, retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_fault     <= FLT_NONE;
            r_bus_valid <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= 32'h0000_0000;
            r_bus_wstrb <= 4'b0000;
            r_hi_wdata  <= 32'h0000_0000;
            r_hi_wstrb  <= 4'b0000;
            r_cross     <= 1'b0;
            r_wait      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_req_ready <= 1'b0;
                        if (!w_size_ok) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_fault <= FLT_SIZE;
                        end else if (!SPLIT_EN && w_cross) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_fault <= FLT_MISALIGN;
                        end else begin
                            r_state     <= ST_BEAT0;
                            r_bus_valid <= 1'b1;
                            r_bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            r_bus_wdata <= w_wdata[31:0];
                            r_bus_wstrb <= w_wstrb[3:0];
                            r_hi_wdata  <= w_wdata[63:32];
                            r_hi_wstrb  <= w_wstrb[7:4];
                            r_cross     <= w_cross;
                            r_wait      <= '0;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                ST_BEAT0, ST_BEAT1: begin
                    if (bus_ready) begin
                        r_wait <= '0;
                        // r_cross can only be set when splitting is enabled.
                        if ((r_state == ST_BEAT0) && r_cross) begin
                            r_state     <= ST_BEAT1;
                            r_bus_addr  <= r_bus_addr + ADDR_W'(32'd4);
                            r_bus_wdata <= r_hi_wdata;
                            r_bus_wstrb <= r_hi_wstrb;
                        end else begin
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_fault     <= FLT_NONE;
                            r_bus_valid <= 1'b0;
                            r_bus_addr  <= '0;
                            r_bus_wdata <= 32'h0000_0000;
                            r_bus_wstrb <= 4'b0000;
                        end
                    end else if (r_wait == CNT_W'(TO_LAST)) begin
                        // An earlier accepted beat stays written; only this
                        // beat is abandoned.
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_fault     <= FLT_TIMEOUT;
                        r_bus_valid <= 1'b0;
                        r_bus_addr  <= '0;
                        r_bus_wdata <= 32'h0000_0000;
                        r_bus_wstrb <= 4'b0000;
                        r_wait      <= '0;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1'b1);
                    end
                end

                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_fault     <= FLT_NONE;
                    r_req_ready <= 1'b1;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_fault     <= FLT_NONE;
                    r_req_ready <= 1'b1;
                    r_bus_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign done      = r_done;
    assign fault     = r_fault;
    assign bus_valid = r_bus_valid;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_mem_store_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_store_unit
// Scoreboard bench: each issued store is run through a byte-level reference
// model whose expected bus beats and retire status are queued; a monitor pops
// and compares whenever a beat is accepted or done pulses. A memory responder
// inserts a chosen number of wait cycles per beat.
// -----------------------------------------------------------------------------
module tb_mem_store_unit;
    import mem_store_unit_pkg::*;

    localparam int T = 16;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    typedef struct {
        logic [1:0] flt;
        int         cyc;
    } done_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_size;
    logic        done;
    logic [1:0]  fault;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t beat_q[$];
    done_t done_q[$];
    int    d_beat[2];
    int    txn_id = 0;
    beat_t mon_b;
    done_t mon_d;

    mem_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .done(done), .fault(fault),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory responder: after a new store, hold bus_ready low for d_beat[n]
    // valid cycles of beat n, then accept. Random while no beat is offered.
    initial begin : responder
        int seen;
        int idx;
        int wcnt;
        seen = 0; idx = 0; wcnt = 0;
        bus_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (txn_id != seen) begin
                seen = txn_id; idx = 0; wcnt = 0;
            end
            if (bus_valid) begin
                if (wcnt >= d_beat[idx]) begin
                    bus_ready = 1'b1; idx = 1; wcnt = 0;
                end else begin
                    bus_ready = 1'b0; wcnt++;
                end
            end else begin
                bus_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compare accepted beats and retire pulses against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!done) chk("fault_when_idle", 64'(fault), 64'(FLT_NONE));
            if (bus_valid && bus_ready) begin
                if (beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=addr %0h required=no beat", bus_addr);
                end else begin
                    mon_b = beat_q.pop_front();
                    chk("beat_addr", 64'(bus_addr), 64'(mon_b.addr));
                    chk("beat_wdata", 64'(bus_wdata), 64'(mon_b.wdata));
                    chk("beat_wstrb", 64'(bus_wstrb), 64'(mon_b.wstrb));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=fault %0d required=no done", fault);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_fault", 64'(fault), 64'(mon_d.flt));
                    chk("done_cycle", 64'(cyc), 64'(mon_d.cyc));
                end
            end
        end
    end

    // Wait (from a posedge+1 point) until the unit is ready, bounded.
    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL wait_idle actual=req_ready 0 required=1 within 100 cycles");
        end
    endtask

    // Byte-level model: data byte k lands at window byte off+k; strobed only
    // for k < access size. Window bytes 0..3 form beat 0, 4..7 beat 1.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] sz, input int d0, input int d1);
        logic [7:0]  win[8];
        logic [7:0]  st8;
        logic [31:0] base;
        int          off, nb, hs, ecyc;
        bit          crosses;
        done_t       de;
        beat_t       be;
        wait_idle();
        hs  = cyc;
        off = int'(a[1:0]);
        nb  = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : (sz == 3'd2) ? 4 : 0;
        for (int j = 0; j < 8; j++) win[j] = 8'h00;
        st8 = 8'h00;
        for (int k = 0; k < 4; k++) begin
            win[off + k] = d[8*k +: 8];
            if (k < nb) st8[off + k] = 1'b1;
        end
        crosses = (off + nb) > 4;
        base    = a - 32'(off);
        ecyc    = hs + 1;
        if (nb == 0) de.flt = FLT_SIZE;
        else if (crosses && !SPLIT) de.flt = FLT_MISALIGN;
        else if (d0 >= T) begin
            de.flt = FLT_TIMEOUT; ecyc += T;
        end else begin
            be.addr = base; be.wdata = {win[3], win[2], win[1], win[0]}; be.wstrb = st8[3:0];
            beat_q.push_back(be);
            ecyc += d0 + 1;
            de.flt = FLT_NONE;
            if (crosses) begin
                if (d1 >= T) begin
                    de.flt = FLT_TIMEOUT; ecyc += T;
                end else begin
                    be.addr = base + 32'd4; be.wdata = {win[7], win[6], win[5], win[4]}; be.wstrb = st8[7:4];
                    beat_q.push_back(be);
                    ecyc += d1 + 1;
                end
            end
        end
        de.cyc = ecyc;
        done_q.push_back(de);
        d_beat[0] = d0; d_beat[1] = d1; txn_id++;
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
        @(posedge clk); #1;
        req_valid = 1'b0;
        begin : wait_done
            for (int i = 0; i < 200; i++) begin
                if (done) disable wait_done;
                // Requests while busy must be ignored.
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = $urandom; req_data = $urandom; req_size = 3'($urandom_range(0, 7));
                @(posedge clk); #1;
            end
            checks++; errors++;
            $display("FAIL wait_done actual=no done required=done within 200 cycles");
        end
        req_valid = 1'b0;
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return T - 1;
        if (r == 1) return T;
        return int'($urandom_range(0, 3));
    endfunction

    initial begin : main
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0; req_size = 3'd0;
        d_beat[0] = 0; d_beat[1] = 0;
        #1;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_bus_valid", 64'(bus_valid), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        chk("rst_bus_wstrb", 64'(bus_wstrb), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        do_store(32'h0000_0100, 32'hDEAD_BEEF, WORD, 0, 0);
        do_store(32'h0000_0103, 32'h0000_00AB, BYTE, 0, 0);
        do_store(32'h0000_0103, 32'h0000_BEEF, HALF_WORD, 0, 0);
        do_store(32'h0000_0200, 32'h1234_5678, WORD, T, 0);
        do_store(32'h0000_0040, 32'hCAFE_F00D, 3'b111, 0, 0);
        do_store(32'h0000_0010, 32'h0BAD_CAFE, WORD, T - 1, 0);
        do_store(32'h0000_0102, 32'hA5A5_5A5A, WORD, 0, T);
        do_store(32'h0000_0101, 32'h1122_3344, WORD, 2, T - 1);
        do_store(32'hFFFF_FFFF, 32'h5566_7788, WORD, 1, 1);
        do_store(32'hFFFF_FFFE, 32'h0000_9ABC, HALF_WORD, 0, 0);

        for (int n = 0; n < 150; n++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? BYTE : (r < 6) ? HALF_WORD : (r < 9) ? WORD : 3'($urandom_range(3, 7));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = {30'h3FFF_FFFF, a[1:0]};
            do_store(a, $urandom, sz, pick_delay(), pick_delay());
        end

        // Reset in the middle of a stalled beat: abandoned, no done pulse.
        wait_idle();
        d_beat[0] = 1000; d_beat[1] = 1000; txn_id++;
        req_valid = 1'b1; req_addr = 32'h0000_0300; req_data = 32'h0F0F_0F0F; req_size = WORD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_beat_valid", 64'(bus_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bus_valid", 64'(bus_valid), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        chk("beat_q_empty", 64'(beat_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_store_unit.md
MEM_STORE_UNIT -- requirements
Module: mem_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of core request and bus address.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum wait cycles for bus_ready per beat before a fault.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  core presents a store.
REQ-006 req_ready  output  1  unit accepts a store this cycle.
REQ-007 req_addr  input  ADDR_W  byte address of the store.
REQ-008 req_data  input  32  store data, right-aligned (rs2).
REQ-009 req_size  input  3  store width as load_size_e: BYTE, HALF_WORD, WORD.
REQ-010 done  output  1  one-cycle pulse when a store retires, including faulted stores.
REQ-011 fault  output  2  store_fault_e, valid while done=1.
REQ-012 bus_valid  output  1  write beat valid.
REQ-013 bus_ready  input  1  memory accepts the beat.
REQ-014 bus_addr  output  ADDR_W  word-aligned address; bits [1:0] always 0.
REQ-015 bus_wdata  output  32  lane-shifted write data.
REQ-016 bus_wstrb  output  4  byte-lane enables.

Function
REQ-017 FSM states: IDLE, BEAT0, BEAT1, DONE.
REQ-018 req_ready=1 only in IDLE; handshake is req_valid & req_ready; IDLE to BEAT0 on handshake, request fields registered.
REQ-019 Lane shift: off=addr[1:0]; wdata = data << 8*off; wstrb = size mask (0001/0011/1111) << off, low 4 bits in BEAT0, high bits in BEAT1.
REQ-020 Invalid req_size encoding: no bus beat, IDLE to DONE, fault=FLT_SIZE.
REQ-021 bus_valid=1 throughout BEAT0/BEAT1; bus_addr, bus_wdata, bus_wstrb stable until bus_valid & bus_ready.
REQ-022 Beat ack in BEAT0: to BEAT1 if the access crosses a word boundary (off+bytes>4), else to DONE.
REQ-023 Beat ack in BEAT1: to DONE; bus_addr = beat0 address + 4, modulo 2^ADDR_W wrap.
REQ-024 Per-beat wait counter cleared on beat entry; reaching TIMEOUT_CYCLES without ack: drop bus_valid, to DONE, fault=FLT_TIMEOUT; a beat already accepted in BEAT0 is not rolled back.
REQ-025 DONE lasts exactly one cycle, done=1, then IDLE; minimum latency handshake to done = 2 cycles (single beat, bus_ready already high).
REQ-026 fault=FLT_NONE whenever done=0.
REQ-027 bus_ready while bus_valid=0 ignored; req_valid outside IDLE ignored.

Reset
REQ-028 rst_n low: state IDLE immediately; req_ready=1 after release; done=0, fault=FLT_NONE, bus_valid=0, bus_addr/wdata/wstrb=0, wait counter 0.
REQ-029 Reset mid-store abandons it with no done pulse; the partially written word is not repaired.

Configuration
REQ-030 Macro MISALIGNED_SPLIT_EN defined: word-crossing stores split into two beats per REQ-022/023.
REQ-031 Macro undefined: a word-crossing store issues no beat, goes IDLE to DONE with fault=FLT_MISALIGN; BEAT1 unreachable.

Structure
REQ-032 Shared types package gains store_fault_e (FLT_NONE, FLT_MISALIGN, FLT_SIZE, FLT_TIMEOUT) and the store FSM state enum; req_size reuses load_size_e.
REQ-033 One sub-module, store_lane_align: combinational off/size/data to wdata and 8-bit wide strobe; FSM and counter stay in mem_store_unit.

Verification
REQ-034 WORD to 0x100, data 0xDEADBEEF, bus_ready=1 -> one beat addr 0x100, wstrb 1111, wdata 0xDEADBEEF; done 2 cycles after handshake, fault NONE.
REQ-035 BYTE to 0x103, data 0x000000AB -> addr 0x100, wstrb 1000, wdata 0xAB000000.
REQ-036 HALF_WORD to 0x103, data 0xBEEF, split enabled -> beat0 addr 0x100 wstrb 1000 wdata[31:24]=0xEF; beat1 addr 0x104 wstrb 0001 wdata[7:0]=0xBE; split disabled -> no beat, fault MISALIGN.
REQ-037 WORD store, bus_ready held low -> bus_valid dropped after TIMEOUT_CYCLES=16 cycles, done with fault TIMEOUT.
REQ-038 req_size=3'b111 -> no beat, done with fault SIZE; rst_n pulsed low during BEAT0 with bus_ready=0 -> bus_valid=0 at once, no done, req_ready=1 after release.
